// File: rtl/mac_array_fix_v2.sv
// A-channel signed fixed-point MAC: shared sample x per-channel weight, summed over a frame, rounded and narrowed.
// Latency: last beat accepted at edge t -> m_valid after edge t+MUL_LAT+1; frames stream back-to-back with no bubble.
// Backpressure: a held result (m_valid & ~m_ready) freezes the whole pipeline and drops s_ready; nothing lost or duplicated.
//
// Ports: clk/rst (sync, active-high); s_data/s_weight/s_valid/s_last/s_ready input beat channel;
//        m_data/m_count/m_ovf/m_valid/m_ready result channel (one vector per frame).
// Build option: define MAC_FIX_V2_SAT_EN to clamp out-of-range results; otherwise they wrap to OUT_W bits.
module mac_array_fix_v2 #(
    parameter int A       = 2,
    parameter int DW      = 32,
    parameter int WW      = 8,
    parameter int ACC_W   = 48,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 8,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        s_data,
    input  logic [A*WW-1:0]      s_weight,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [A*OUT_W-1:0]   m_data,
    output logic [CNT_W-1:0]     m_count,
    output logic [A-1:0]         m_ovf,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int PW = DW + WW;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Half-LSB of the shifted result, added before the arithmetic shift for round-half-up.
    localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RS) : '0;
    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
    localparam int HI_W = ACC_W - OUT_W + 2;

    // A held result stalls every stage at once so relative beat order never changes.
    logic stall;
    assign stall   = m_valid & ~m_ready;
    assign s_ready = ~stall;

    // ---------------- multiplier pipeline ----------------
    logic signed [PW-1:0] prod [A];
    logic                 pv   [MUL_LAT];
    logic                 pl   [MUL_LAT];
    logic signed [PW-1:0] pp   [MUL_LAT][A];

    always_comb begin
        for (int i = 0; i < A; i++) begin
            prod[i] = $signed(s_data) * $signed(s_weight[i*WW +: WW]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                pv[k] <= 1'b0;
                pl[k] <= 1'b0;
                for (int i = 0; i < A; i++) pp[k][i] <= '0;
            end
        end else if (!stall) begin
            pv[0] <= s_valid;
            pl[0] <= s_last;
            for (int i = 0; i < A; i++) pp[0][i] <= prod[i];
            for (int k = 1; k < MUL_LAT; k++) begin
                pv[k] <= pv[k-1];
                pl[k] <= pl[k-1];
                for (int i = 0; i < A; i++) pp[k][i] <= pp[k-1][i];
            end
        end
    end

    // ---------------- accumulate stage ----------------
    logic signed [ACC_W-1:0] pext [A];
    logic signed [ACC_W-1:0] acc  [A];
    logic [CNT_W-1:0]        cnt;
    logic                    first;  // next accumulated beat opens a new frame
    logic                    fin;    // acc/cnt hold a completed frame awaiting the output register

    always_comb begin
        for (int i = 0; i < A; i++) begin
            pext[i] = ACC_W'(pp[MUL_LAT-1][i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < A; i++) acc[i] <= '0;
            cnt   <= '0;
            first <= 1'b1;
            fin   <= 1'b0;
        end else if (!stall) begin
            fin <= pv[MUL_LAT-1] & pl[MUL_LAT-1];
            if (pv[MUL_LAT-1]) begin
                for (int i = 0; i < A; i++) begin
                    acc[i] <= first ? pext[i] : acc[i] + pext[i];
                end
                if (first)
                    cnt <= CNT_W'(1);
                else if (cnt != {CNT_W{1'b1}})
                    cnt <= cnt + 1'b1;
                first <= pl[MUL_LAT-1];
            end
        end
    end

    // ---------------- round, narrow, overflow ----------------
    // One guard bit above ACC_W keeps the rounding add from wrapping.
    logic signed [ACC_W:0] rnd_v;
    logic signed [ACC_W:0] tsh;
    logic [HI_W-1:0]       hi;
    logic [A*OUT_W-1:0]    nar;
    logic [A-1:0]          ovf_v;

    always_comb begin
        rnd_v = '0;
        tsh   = '0;
        hi    = '0;
        nar   = '0;
        ovf_v = '0;
        for (int i = 0; i < A; i++) begin
            rnd_v = $signed({acc[i][ACC_W-1], acc[i]} + RND);
            tsh   = rnd_v >>> SHIFT;
            // In range iff every bit from the OUT_W sign bit upward matches.
            hi       = tsh[ACC_W:OUT_W-1];
            ovf_v[i] = ~((&hi) | ~(|hi));
`ifdef MAC_FIX_V2_SAT_EN
            nar[i*OUT_W +: OUT_W] = ovf_v[i] ? (tsh[ACC_W] ? MIN_V : MAX_V) : tsh[OUT_W-1:0];
`else
            nar[i*OUT_W +: OUT_W] = tsh[OUT_W-1:0];
`endif
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
            m_ovf   <= '0;
        end else if (!stall) begin
            m_valid <= fin;
            if (fin) begin
                m_data  <= nar;
                m_count <= cnt;
                m_ovf   <= ovf_v;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_fix_v2.sv
// Bench for mac_array_fix_v2: two instances (SHIFT=0 and SHIFT=2) share one input stream and m_ready.
// Latency: n/a (testbench).
// Backpressure: m_ready driven directly and randomly; results compared in order against a frame-level arithmetic model.
module tb_mac_array_fix_v2;

    localparam int MUL_LAT = 2;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] cnt;
        logic [1:0]  ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic [15:0] s_weight;
    logic        s_valid, s_last, m_ready;
    logic        s_ready0, s_ready1, m_valid0, m_valid1;
    logic [15:0] m_data0, m_data1, m_count0, m_count1;
    logic [1:0]  m_ovf0, m_ovf1;

    always #5 clk = ~clk;

    mac_array_fix_v2 #(.SHIFT(0), .MUL_LAT(MUL_LAT)) u_dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_weight(s_weight), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready0), .m_data(m_data0), .m_count(m_count0),
        .m_ovf(m_ovf0), .m_valid(m_valid0), .m_ready(m_ready));

    mac_array_fix_v2 #(.SHIFT(2), .MUL_LAT(MUL_LAT)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_weight(s_weight), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready1), .m_data(m_data1), .m_count(m_count1),
        .m_ovf(m_ovf1), .m_valid(m_valid1), .m_ready(m_ready));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint sum [2][2];
    int     mcnt [2];
    bit     mfirst [2];
    res_t   q0[$], q1[$];
    int     delivered0 = 0;
    res_t   last0, last1;

    function automatic logic [7:0] narrow(input longint r, input int sh, output bit ov);
        longint t;
        t  = (sh > 0) ? ((r + (longint'(1) <<< (sh - 1))) >>> sh) : r;
        ov = (t > 127) || (t < -128);
`ifdef MAC_FIX_V2_SAT_EN
        if (t > 127) t = 127;
        else if (t < -128) t = -128;
`endif
        return t[7:0];
    endfunction

    task automatic model_beat();
        int     x;
        byte    wc [2];
        longint p, s;
        res_t   e;
        bit     ov;
        logic [7:0] nv;
        x     = int'($signed(s_data));
        wc[0] = byte'(s_weight[7:0]);
        wc[1] = byte'(s_weight[15:8]);
        for (int d = 0; d < 2; d++) begin
            e = '0;
            for (int c = 0; c < 2; c++) begin
                p = longint'(x) * longint'(wc[c]);
                s = mfirst[d] ? p : sum[d][c] + p;
                s = (s <<< 16) >>> 16;  // modulo 2^48, signed
                sum[d][c] = s;
                nv = narrow(s, (d == 0) ? 0 : 2, ov);
                e.data[c*8 +: 8] = nv;
                e.ovf[c] = ov;
            end
            mcnt[d] = mfirst[d] ? 1 : ((mcnt[d] == 65535) ? 65535 : mcnt[d] + 1);
            e.cnt = 16'(mcnt[d]);
            if (s_last) begin
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            mfirst[d] = s_last;
        end
    endtask

    // Beats and handshakes are observed mid-cycle; they take effect on the following rising edge.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            mfirst[0] = 1'b1;
            mfirst[1] = 1'b1;
            q0.delete();
            q1.delete();
        end else begin
            if (s_valid && s_ready0) model_beat();
            if (m_valid0 && m_ready) begin
                last0 = {m_data0, m_count0, m_ovf0};
                delivered0++;
                if (q0.size() == 0) chk("unexpected_result0", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("data0", m_data0, e.data);
                    chk("count0", m_count0, e.cnt);
                    chk("ovf0", m_ovf0, e.ovf);
                end
            end
            if (m_valid1 && m_ready) begin
                last1 = {m_data1, m_count1, m_ovf1};
                if (q1.size() == 0) chk("unexpected_result1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("data1", m_data1, e.data);
                    chk("count1", m_count1, e.cnt);
                    chk("ovf1", m_ovf1, e.ovf);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input int x, input byte w0, input byte w1, input bit last);
        int k;
        s_data   = x;
        s_weight = {w1, w0};
        s_last   = last;
        s_valid  = 1'b1;
        k = 0;
        @(negedge clk);
        while (!s_ready0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("accept_timeout", k, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int   n, d0;
    int   rv [4] = '{6, 5, -6, -7};
    int   re [4] = '{2, 1, -1, -2};
    logic [15:0] held;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_weight = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_m_valid", m_valid0, 0);
        chk("rst_m_data", m_data0, 0);
        chk("rst_m_count", m_count0, 0);
        chk("rst_m_ovf", m_ovf0, 0);
        chk("rst_s_ready", s_ready0, 1);

        // three-beat frame
        send_beat(3, 2, -1, 0);
        send_beat(4, 2, -1, 0);
        send_beat(5, 2, -1, 1);
        drain();
        chk("t1_ch0", longint'($signed(last0.data[7:0])), 24);
        chk("t1_ch1", longint'($signed(last0.data[15:8])), -12);
        chk("t1_count", last0.cnt, 3);
        chk("t1_ovf", last0.ovf, 0);

        // latency of a single-beat frame
        s_data = 7; s_weight = {8'd0, 8'd1}; s_last = 1'b1; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0; s_last = 1'b0;
        n = 0;
        while (!m_valid0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t2_latency", n, MUL_LAT + 1);
        drain();
        chk("t2_ch0", longint'($signed(last0.data[7:0])), 7);

        // narrowing overflow
        send_beat(100, 2, 0, 1);
        drain();
`ifdef MAC_FIX_V2_SAT_EN
        chk("t3_ch0", longint'($signed(last0.data[7:0])), 127);
`else
        chk("t3_ch0", longint'($signed(last0.data[7:0])), -56);
`endif
        chk("t3_ovf0", last0.ovf[0], 1);

        // round half up with SHIFT=2
        for (int i = 0; i < 4; i++) begin
            send_beat(rv[i], 1, 0, 1);
            drain();
            chk("t4_round", longint'($signed(last1.data[7:0])), re[i]);
        end

        // backpressure with two queued single-beat frames
        d0 = delivered0;
        m_ready = 1'b0;
        send_beat(11, 3, 1, 1);
        send_beat(12, -3, 2, 1);
        n = 0;
        while (!m_valid0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        held = m_data0;
        repeat (10) begin
            @(negedge clk);
            chk("t5_s_ready_held", s_ready0, 0);
            chk("t5_data_stable", m_data0, held);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        drain();
        chk("t5_delivered", delivered0 - d0, 2);

        // reset in the middle of a frame
        send_beat(9, 4, 4, 0);
        send_beat(9, 4, 4, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_rst_m_valid", m_valid0, 0);
        chk("t6_rst_s_ready", s_ready0, 1);
        d0 = delivered0;
        send_beat(1, 5, 0, 1);
        drain();
        repeat (10) @(posedge clk);
        #1;
        chk("t6_delivered", delivered0 - d0, 1);
        chk("t6_ch0", longint'($signed(last0.data[7:0])), 5);
        chk("t6_count", last0.cnt, 1);

        // randomized traffic with random downstream stalls
        for (int i = 0; i < 600; i++) begin
            s_valid  = ($urandom_range(0, 2) != 0);
            s_data   = $urandom_range(0, 2000) - 1000;
            s_weight = 16'($urandom);
            s_last   = ($urandom_range(0, 3) == 0);
            m_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        send_beat(1, 1, 1, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
